// File: rtl/eth_stats_pkg.sv
// eth_stats_pkg
// Shared definitions for the Ethernet statistics collector:
//   - bit positions of the TEMAC RX/TX statistics vector fields
//   - the decoded per-frame increment record carried from decode to accumulate
package eth_stats_pkg;

    localparam int RX_GOOD_BIT = 0;
    localparam int RX_BAD_BIT  = 1;
    localparam int RX_FCS_BIT  = 2;
    localparam int LEN_LSB     = 5;
    localparam int LEN_MSB     = 18;
    localparam int TX_GOOD_BIT = 0;

    localparam int LEN_W = LEN_MSB - LEN_LSB + 1;

    typedef struct packed {
        logic             good;
        logic             bad;
        logic             fcs;
        logic [LEN_W-1:0] len;
    } stats_inc_t;

endpackage

// File: rtl/eth_stats_path.sv
// eth_stats_path
// Decode stage plus counters and snapshot registers for one traffic direction.
// IS_TX selects the TX decode rules (bad = !good, no FCS); otherwise RX rules.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   enable               gates new statistics vectors into the decode stage
//   clear                zero all counters (stage-2 increment in that cycle dropped)
//   snap_req             copy current counters into the snapshot registers
//   stats_vector/valid   TEMAC statistics vector and its qualifier
//   snap_good/bad/fcs/bytes  snapshot outputs
import eth_stats_pkg::*;

module eth_stats_path #(
    parameter int CNT_W = 64,
    parameter int VEC_W = 28,
    parameter bit IS_TX = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             snap_req,
    input  logic [VEC_W-1:0] stats_vector,
    input  logic             stats_valid,
    output logic [CNT_W-1:0] snap_good,
    output logic [CNT_W-1:0] snap_bad,
    output logic [CNT_W-1:0] snap_fcs,
    output logic [CNT_W-1:0] snap_bytes
);

    // Reserved vector bits carry nothing we count; fold them so every bit is consumed.
    logic vec_unused;
    assign vec_unused = ^stats_vector;

    function automatic stats_inc_t decode(input logic [VEC_W-1:0] v);
        stats_inc_t d;
        d = '0;
        if (IS_TX) begin
            d.good = v[TX_GOOD_BIT];
            d.bad  = !v[TX_GOOD_BIT];
            d.fcs  = 1'b0;
        end else begin
            d.good = v[RX_GOOD_BIT];
            d.bad  = v[RX_BAD_BIT];
            d.fcs  = v[RX_FCS_BIT];
        end
        // Only good frames contribute to the byte count.
        d.len = d.good ? v[LEN_MSB:LEN_LSB] : '0;
        return d;
    endfunction

    stats_inc_t       inc_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] cnt_good;
    logic [CNT_W-1:0] cnt_bad;
    logic [CNT_W-1:0] cnt_fcs;
    logic [CNT_W-1:0] cnt_bytes;

    // ---- stage 1: decode ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            inc_p1 <= '0;
        end else begin
            vld_p1 <= stats_valid && enable;
            inc_p1 <= (stats_valid && enable) ? decode(stats_vector) : '0;
        end
    end

    // ---- stage 2: accumulate (wraps modulo 2^CNT_W) ----
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_good  <= '0;
            cnt_bad   <= '0;
            cnt_fcs   <= '0;
            cnt_bytes <= '0;
        end else if (vld_p1) begin
            cnt_good  <= cnt_good  + CNT_W'(inc_p1.good);
            cnt_bad   <= cnt_bad   + CNT_W'(inc_p1.bad);
            cnt_fcs   <= cnt_fcs   + CNT_W'(inc_p1.fcs);
            cnt_bytes <= cnt_bytes + CNT_W'(inc_p1.len);
        end
    end

    // ---- snapshot: captures pre-update counter values, so a same-cycle
    // clear still yields the values being cleared ----
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_good  <= '0;
            snap_bad   <= '0;
            snap_fcs   <= '0;
            snap_bytes <= '0;
        end else if (snap_req) begin
            snap_good  <= cnt_good;
            snap_bad   <= cnt_bad;
            snap_fcs   <= cnt_fcs;
            snap_bytes <= cnt_bytes;
        end
    end

endmodule

// File: rtl/eth_stats_collector.sv
// eth_stats_collector
// Per-interface Ethernet traffic counters fed by the TEMAC RX/TX statistics
// vectors, with atomic snapshot and optional atomic clear for register readout.
// Ports:
//   clk, rst                       TEMAC user clock, synchronous active-high reset
//   enable                         ignore new statistics vectors when low
//   clear, snap_req                one-cycle pulses shared by both directions
//   rx_stats_vector/rx_stats_valid RX statistics (28 bits)
//   tx_stats_vector/tx_stats_valid TX statistics (32 bits)
//   snap_rx_*, snap_tx_*           snapshot values, held until the next snap_req
//   snap_valid                     pulses the cycle after snap_req
import eth_stats_pkg::*;

module eth_stats_collector #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             snap_req,
    input  logic [27:0]      rx_stats_vector,
    input  logic             rx_stats_valid,
    input  logic [31:0]      tx_stats_vector,
    input  logic             tx_stats_valid,
    output logic [CNT_W-1:0] snap_rx_good,
    output logic [CNT_W-1:0] snap_rx_bad,
    output logic [CNT_W-1:0] snap_rx_fcs,
    output logic [CNT_W-1:0] snap_rx_bytes,
    output logic [CNT_W-1:0] snap_tx_good,
    output logic [CNT_W-1:0] snap_tx_bad,
    output logic [CNT_W-1:0] snap_tx_bytes,
    output logic             snap_valid
);

    // TX has no FCS counter; the path's fcs output stays at zero.
    logic [CNT_W-1:0] tx_fcs_unused;

    eth_stats_path #(
        .CNT_W (CNT_W),
        .VEC_W (28),
        .IS_TX (1'b0)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .snap_req     (snap_req),
        .stats_vector (rx_stats_vector),
        .stats_valid  (rx_stats_valid),
        .snap_good    (snap_rx_good),
        .snap_bad     (snap_rx_bad),
        .snap_fcs     (snap_rx_fcs),
        .snap_bytes   (snap_rx_bytes)
    );

    eth_stats_path #(
        .CNT_W (CNT_W),
        .VEC_W (32),
        .IS_TX (1'b1)
    ) u_tx (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .snap_req     (snap_req),
        .stats_vector (tx_stats_vector),
        .stats_valid  (tx_stats_valid),
        .snap_good    (snap_tx_good),
        .snap_bad     (snap_tx_bad),
        .snap_fcs     (tx_fcs_unused),
        .snap_bytes   (snap_tx_bytes)
    );

    // ---- snapshot strobe, aligned with the snapshot registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= snap_req;
        end
    end

endmodule

// File: tb/tb_eth_stats_collector.sv
module tb_eth_stats_collector;

    localparam int CNT_W = 64;
    localparam logic [63:0] PRELOAD = 64'hFFFF_FFFF_FFFF_FFF6;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             clear;
    logic             snap_req;
    logic [27:0]      rx_stats_vector;
    logic             rx_stats_valid;
    logic [31:0]      tx_stats_vector;
    logic             tx_stats_valid;
    logic [CNT_W-1:0] snap_rx_good, snap_rx_bad, snap_rx_fcs, snap_rx_bytes;
    logic [CNT_W-1:0] snap_tx_good, snap_tx_bad, snap_tx_bytes;
    logic             snap_valid;

    always #5 clk = ~clk;

    eth_stats_collector #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .clear           (clear),
        .snap_req        (snap_req),
        .rx_stats_vector (rx_stats_vector),
        .rx_stats_valid  (rx_stats_valid),
        .tx_stats_vector (tx_stats_vector),
        .tx_stats_valid  (tx_stats_valid),
        .snap_rx_good    (snap_rx_good),
        .snap_rx_bad     (snap_rx_bad),
        .snap_rx_fcs     (snap_rx_fcs),
        .snap_rx_bytes   (snap_rx_bytes),
        .snap_tx_good    (snap_tx_good),
        .snap_tx_bad     (snap_tx_bad),
        .snap_tx_bytes   (snap_tx_bytes),
        .snap_valid      (snap_valid)
    );

    // Model: totals index 0 rx_good, 1 rx_bad, 2 rx_fcs, 3 rx_bytes,
    // 4 tx_good, 5 tx_bad, 6 tx_bytes. An event seen at a clock edge is
    // held as "pending" and lands in the totals at the following edge.
    logic [63:0] tot  [7];
    logic [63:0] snap [7];
    logic [63:0] pend [7];
    logic        m_snap_valid;
    logic        preload_on = 1'b0;

    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                tot[i]  = '0;
                snap[i] = '0;
                pend[i] = '0;
            end
            m_snap_valid = 1'b0;
        end else begin
            m_snap_valid = snap_req;
            if (snap_req)
                for (int i = 0; i < 7; i++) snap[i] = tot[i];
            for (int i = 0; i < 7; i++) tot[i] = clear ? 64'd0 : tot[i] + pend[i];
            if (preload_on) tot[3] = PRELOAD;
            for (int i = 0; i < 7; i++) pend[i] = '0;
            if (rx_stats_valid && enable) begin
                pend[0] = {63'd0, rx_stats_vector[0]};
                pend[1] = {63'd0, rx_stats_vector[1]};
                pend[2] = {63'd0, rx_stats_vector[2]};
                pend[3] = rx_stats_vector[0] ? {50'd0, rx_stats_vector[18:5]} : 64'd0;
            end
            if (tx_stats_valid && enable) begin
                pend[4] = {63'd0, tx_stats_vector[0]};
                pend[5] = {63'd0, !tx_stats_vector[0]};
                pend[6] = tx_stats_vector[0] ? {50'd0, tx_stats_vector[18:5]} : 64'd0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("cyc_rx_good",  snap_rx_good,  snap[0]);
            chk("cyc_rx_bad",   snap_rx_bad,   snap[1]);
            chk("cyc_rx_fcs",   snap_rx_fcs,   snap[2]);
            chk("cyc_rx_bytes", snap_rx_bytes, snap[3]);
            chk("cyc_tx_good",  snap_tx_good,  snap[4]);
            chk("cyc_tx_bad",   snap_tx_bad,   snap[5]);
            chk("cyc_tx_bytes", snap_tx_bytes, snap[6]);
            chk("cyc_snap_valid", {63'd0, snap_valid}, {63'd0, m_snap_valid});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rx_stats_valid = 1'b0;
        tx_stats_valid = 1'b0;
        snap_req       = 1'b0;
        clear          = 1'b0;
    endtask

    function automatic logic [27:0] rxv(input logic g, input logic b, input logic f, input int len);
        logic [27:0] v;
        v = '0;
        v[0] = g;
        v[1] = b;
        v[2] = f;
        v[18:5] = len[13:0];
        return v;
    endfunction

    function automatic logic [31:0] txv(input logic g, input int len);
        logic [31:0] v;
        v = '0;
        v[0] = g;
        v[18:5] = len[13:0];
        return v;
    endfunction

    task automatic snap_now();
        snap_req = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; clear = 1'b0; snap_req = 1'b0;
        rx_stats_vector = '0; rx_stats_valid = 1'b0;
        tx_stats_vector = '0; tx_stats_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        fork
            compare_loop();
        join_none

        chk("reset_rx_good", snap_rx_good, 64'd0);
        chk("reset_tx_bytes", snap_tx_bytes, 64'd0);
        chk("reset_snap_valid", {63'd0, snap_valid}, 64'd0);

        // Three good RX frames
        rx_stats_vector = rxv(1, 0, 0, 64);   rx_stats_valid = 1'b1; step();
        rx_stats_vector = rxv(1, 0, 0, 100);  rx_stats_valid = 1'b1; step();
        rx_stats_vector = rxv(1, 0, 0, 1518); rx_stats_valid = 1'b1; step();
        step();
        snap_now();
        chk("t1_rx_good", snap_rx_good, 64'd3);
        chk("t1_rx_bytes", snap_rx_bytes, 64'd1682);
        chk("t1_rx_bad", snap_rx_bad, 64'd0);
        chk("t1_snap_valid_hi", {63'd0, snap_valid}, 64'd1);
        step();
        chk("t1_snap_valid_lo", {63'd0, snap_valid}, 64'd0);

        // Bad+FCS RX frame, failed TX frame
        rx_stats_vector = rxv(0, 1, 1, 70); rx_stats_valid = 1'b1;
        tx_stats_vector = txv(0, 100);      tx_stats_valid = 1'b1;
        step(); step();
        snap_now();
        chk("t2_rx_bad", snap_rx_bad, 64'd1);
        chk("t2_rx_fcs", snap_rx_fcs, 64'd1);
        chk("t2_rx_bytes", snap_rx_bytes, 64'd1682);
        chk("t2_tx_bad", snap_tx_bad, 64'd1);
        chk("t2_tx_bytes", snap_tx_bytes, 64'd0);

        // snap_req at N+1 excludes, at N+2 includes
        rx_stats_vector = rxv(1, 0, 0, 10); rx_stats_valid = 1'b1; step();
        snap_now();
        chk("t3_excl_good", snap_rx_good, 64'd3);
        snap_now();
        chk("t3_incl_good", snap_rx_good, 64'd4);
        chk("t3_incl_bytes", snap_rx_bytes, 64'd1692);

        // Atomic read-and-clear
        for (int i = 0; i < 5; i++) begin
            tx_stats_vector = txv(1, 64); tx_stats_valid = 1'b1; step();
        end
        step();
        clear = 1'b1;
        snap_now();
        chk("t4_tx_good", snap_tx_good, 64'd5);
        chk("t4_tx_bytes", snap_tx_bytes, 64'd320);
        chk("t4_tx_bad", snap_tx_bad, 64'd1);
        step();
        snap_now();
        chk("t4_after_clr_tx_good", snap_tx_good, 64'd0);
        chk("t4_after_clr_rx_good", snap_rx_good, 64'd0);

        // Byte counter wrap
        preload_on = 1'b1;
        force dut.u_rx.cnt_bytes = PRELOAD;
        step();
        release dut.u_rx.cnt_bytes;
        preload_on = 1'b0;
        rx_stats_vector = rxv(1, 0, 0, 64); rx_stats_valid = 1'b1; step();
        step();
        snap_now();
        chk("t5_wrap_bytes", snap_rx_bytes, 64'd54);
        chk("t5_wrap_good", snap_rx_good, 64'd1);

        // Disabled input
        clear = 1'b1; step();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx_stats_vector = rxv(1, 0, 0, 64); rx_stats_valid = 1'b1;
            tx_stats_vector = txv(1, 64);       tx_stats_valid = 1'b1;
            step();
        end
        enable = 1'b1;
        step();
        snap_now();
        chk("t6_dis_rx_good", snap_rx_good, 64'd0);
        chk("t6_dis_tx_good", snap_tx_good, 64'd0);
        chk("t6_dis_rx_bytes", snap_rx_bytes, 64'd0);

        // Back-to-back streaming
        for (int i = 0; i < 100; i++) begin
            rx_stats_vector = rxv(1, 0, 0, 64); rx_stats_valid = 1'b1;
            tx_stats_vector = txv(1, 64);       tx_stats_valid = 1'b1;
            step();
        end
        step();
        snap_now();
        chk("t7_rx_good", snap_rx_good, 64'd100);
        chk("t7_tx_good", snap_tx_good, 64'd100);
        chk("t7_rx_bytes", snap_rx_bytes, 64'd6400);
        chk("t7_tx_bytes", snap_tx_bytes, 64'd6400);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) begin
            rx_stats_vector = rxv(1, 0, 0, 64); rx_stats_valid = 1'b1;
            tx_stats_vector = txv(1, 64);       tx_stats_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        rx_stats_vector = rxv(1, 0, 0, 64); rx_stats_valid = 1'b1;
        tx_stats_vector = txv(1, 64);       tx_stats_valid = 1'b1;
        snap_req = 1'b1;
        step();
        chk("t8_rst_rx_good", snap_rx_good, 64'd0);
        chk("t8_rst_tx_good", snap_tx_good, 64'd0);
        chk("t8_rst_rx_bytes", snap_rx_bytes, 64'd0);
        chk("t8_rst_snap_valid", {63'd0, snap_valid}, 64'd0);
        rst = 1'b0;
        step(); step();
        snap_now();
        chk("t8_post_rx_good", snap_rx_good, 64'd0);
        chk("t8_post_tx_good", snap_tx_good, 64'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
